// File: rtl/coherent_dir_mctrl.sv
// Directory-based line memory controller: 2-bit coherence state per line, line reads streamed
// onto the RDreturn bus, line writes from the md FIFO, and ack/retry entries for the resend queue.
module coherent_dir_mctrl #(
  parameter int MBITS        = 24,
  parameter int LINE_LOG     = 3,
  parameter int PRESET_LINES = 128,
  parameter int DEST_W       = 4
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              ma_empty_i,
  input  logic [31:0]       ma_addr_i,
  input  logic [DEST_W-1:0] ma_dest_i,
  output logic              ma_rd_o,
  input  logic              md_empty_i,
  input  logic [31:0]       md_data_i,
  output logic              md_rd_o,
  output logic [MBITS-1:0]  mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       rd_return_o,
  output logic [DEST_W-1:0] rd_dest_o,
  output logic              rs_valid_o,
  input  logic              rs_ready_i,
  output logic [39:0]       rs_data_o,
  output logic              busy_o,
  output logic              err_oor_o,
  output logic [15:0]       nack_cnt_o
);

  localparam int LINES_W   = MBITS - LINE_LOG;
  localparam int DIR_LINES = 1 << LINES_W;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_WRITE, S_RSEND} state_e;
  typedef enum logic [1:0] {DIR_CLEAN = 2'd0, DIR_WAITING = 2'd1, DIR_MODIFIED = 2'd2} dir_e;

  state_e              state_q;
  logic [LINES_W-1:0]  idx_q, line_q;
  logic [LINE_LOG-1:0] cnt_q;
  logic [DEST_W-1:0]   dest_q, rd_dest_q;
  logic [39:0]         rs_data_q;
  logic [15:0]         nack_q;
  logic                busy_q, err_q, rv_q;
  dir_e                dir_q [DIR_LINES];

  // Request decode of the address FIFO head
  logic               req_valid, req_oor, req_retry, req_ack_only, req_excl, req_read;
  logic               rd_possible, last_word;
  logic [LINES_W-1:0] req_line;
  logic [3:0]         dest4;
  dir_e               cur_dir;

  assign req_valid    = (state_q == S_IDLE) && !ma_empty_i;
  assign req_retry    = ma_addr_i[31];
  assign req_ack_only = ma_addr_i[30];
  assign req_excl     = ma_addr_i[29];
  assign req_read     = ma_addr_i[28];
  assign req_line     = ma_addr_i[LINES_W-1:0];
  assign req_oor      = (ma_addr_i[27:0] >> LINES_W) != '0;
  assign cur_dir      = dir_q[req_line];
  assign rd_possible  = (cur_dir == DIR_CLEAN) || ((cur_dir == DIR_WAITING) && req_retry);
  assign last_word    = (cnt_q == '1);
  assign dest4        = 4'(ma_dest_i);

  logic               dir_we;
  logic [LINES_W-1:0] dir_widx;
  dir_e               dir_wval;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dir_we   = 1'b0;
    dir_widx = idx_q;
    dir_wval = DIR_CLEAN;
    if (state_q == S_INIT) begin
      dir_we   = 1'b1;
      dir_wval = (32'(idx_q) < PRESET_LINES) ? DIR_MODIFIED : DIR_CLEAN;
    end else if (req_valid && !req_oor) begin
      dir_widx = req_line;
      if (req_read) begin
        dir_we   = rd_possible;
        dir_wval = req_excl ? DIR_MODIFIED : DIR_CLEAN;
      end else begin
        dir_we   = 1'b1;
        dir_wval = req_excl ? DIR_WAITING : DIR_CLEAN;
      end
    end
  end

  // NOTE: the directory array has no reset; the INIT sweep after every reset defines its contents.
  always_ff @(posedge clock_i) begin
    if (dir_we) dir_q[dir_widx] <= dir_wval;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_INIT;
      idx_q     <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      rd_dest_q <= '0;
      rs_data_q <= '0;
      nack_q    <= '0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      rv_q      <= (state_q == S_READ);
      rd_dest_q <= (state_q == S_READ) ? dest_q : '0;
      case (state_q)
        S_INIT: begin
          idx_q <= idx_q + LINES_W'(1);
          if (idx_q == '1) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!ma_empty_i) begin
            if (req_oor) begin
              err_q <= 1'b1;
            end else begin
              line_q <= req_line;
              dest_q <= ma_dest_i;
              cnt_q  <= '0;
              if (!req_read) begin
                state_q <= S_WRITE;
              end else if (!rd_possible) begin
                rs_data_q <= {dest4, 4'h2, 2'b10, ma_addr_i[29:0]};
                if (nack_q != '1) nack_q <= nack_q + 16'd1;
                state_q <= S_RSEND;
              end else if (req_ack_only) begin
                rs_data_q <= {dest4, 4'h6, 4'h0, ma_addr_i[27:0]};
                state_q   <= S_RSEND;
              end else begin
                state_q <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + LINE_LOG'(1);
          if (last_word) state_q <= S_IDLE;
        end
        S_WRITE: begin
          if (!md_empty_i) begin
            cnt_q <= cnt_q + LINE_LOG'(1);
            if (last_word) state_q <= S_IDLE;
          end
        end
        S_RSEND: begin
          if (rs_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Strobes decode from registered state; write/pop follow the md/rs handshakes in the same cycle
  assign mem_re_o    = (state_q == S_READ);
  assign mem_we_o    = (state_q == S_WRITE) && !md_empty_i;
  assign md_rd_o     = mem_we_o;
  assign mem_addr_o  = {line_q, cnt_q};
  assign mem_wdata_o = md_data_i;
  assign ma_rd_o     = (req_valid && req_oor)
                     || ((state_q == S_READ) && last_word)
                     || (mem_we_o && last_word)
                     || ((state_q == S_RSEND) && rs_ready_i);
  assign rs_valid_o  = (state_q == S_RSEND);
  assign rs_data_o   = rs_data_q;
  assign rd_return_o = rv_q ? mem_rdata_i : '0;
  assign rd_dest_o   = rd_dest_q;
  assign busy_o      = busy_q;
  assign err_oor_o   = err_q;
  assign nack_cnt_o  = nack_q;

endmodule

// File: tb/tb_coherent_dir_mctrl.sv
// Bench for coherent_dir_mctrl: directed coherence scenarios plus random requests, checked against
// a line-level model of the directory, memory contents and resend entries.
module tb_coherent_dir_mctrl;

  localparam int MB        = 14;
  localparam int LL        = 3;
  localparam int LW        = 8;
  localparam int DIR_LINES = 2048;
  localparam int PRESET    = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ma_empty, ma_rd, md_empty, md_rd;
  logic [31:0] ma_addr, md_data, mem_wdata, mem_rdata, rd_return;
  logic [3:0]  ma_dest, rd_dest;
  logic [MB-1:0] mem_addr;
  logic        mem_re, mem_we, rs_valid, rs_ready, busy, err_oor;
  logic [39:0] rs_data;
  logic [15:0] nack_cnt;

  always #5 clk = ~clk;

  coherent_dir_mctrl #(.MBITS(MB), .LINE_LOG(LL), .PRESET_LINES(PRESET), .DEST_W(4)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .ma_empty_i(ma_empty), .ma_addr_i(ma_addr), .ma_dest_i(ma_dest), .ma_rd_o(ma_rd),
    .md_empty_i(md_empty), .md_data_i(md_data), .md_rd_o(md_rd),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .rd_return_o(rd_return), .rd_dest_o(rd_dest),
    .rs_valid_o(rs_valid), .rs_ready_i(rs_ready), .rs_data_o(rs_data),
    .busy_o(busy), .err_oor_o(err_oor), .nack_cnt_o(nack_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: directory per line, memory words written so far, retry count
  int          ref_dir [DIR_LINES];
  logic [31:0] ref_mem [int];
  int          ref_nack;

  // Memory with one cycle registered read latency
  logic [31:0] env_mem [int];

  function automatic logic [31:0] pat(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : pat(int'(mem_addr));
    if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIR_LINES; i++) ref_dir[i] = (i < PRESET) ? 2 : 0;
    ref_nack = 0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    int ipop = 0;
    #1;
    while (busy && n < 5000) begin
      n++;
      if (ma_rd) ipop++;
      @(negedge clk);
      #1;
    end
    ma_empty = 1'b1;
    check({tag, ".busy_cycles"}, 64'(n), 64'(DIR_LINES));
    check({tag, ".init_pops"}, 64'(ipop), 64'd0);
    model_reset();
  endtask

  // One request from the address FIFO head, run to its pop plus two drain cycles
  task automatic run_req(input string tag, input logic [31:0] addr, input logic [3:0] dest,
                         input int ready_delay, input int stall_at, input int stall_len);
    int line = int'(addr[10:0]);
    bit oor  = (addr[27:11] != 0);
    int kind;  // 0 oor, 1 data read, 2 ack, 3 retry, 4 write
    int d;
    logic [39:0] exp_rs = '0;
    logic [31:0] md_words [LW];
    logic [31:0] exp_words [LW];
    int pops = 0, post = 0, rd_n = 0, rd_first = -1, re_n = 0, wr_n = 0, wr_empty = 0;
    int rs_n = 0, err_n = 0, wr_idx = 0;
    bit popped = 0;

    if (oor) kind = 0;
    else if (addr[28]) begin
      d = ref_dir[line];
      if (d == 0 || (d == 1 && addr[31])) begin
        ref_dir[line] = addr[29] ? 2 : 0;
        kind = addr[30] ? 2 : 1;
        exp_rs = {dest, 4'h6, 4'h0, addr[27:0]};
      end else begin
        kind = 3;
        exp_rs = {dest, 4'h2, 2'b10, addr[29:0]};
        if (ref_nack < 65535) ref_nack++;
      end
    end else begin
      ref_dir[line] = addr[29] ? 1 : 0;
      kind = 4;
    end
    for (int i = 0; i < LW; i++) begin
      int wa = line * LW + i;
      exp_words[i] = ref_mem.exists(wa) ? ref_mem[wa] : pat(wa);
      md_words[i]  = $urandom;
      if (kind == 4) ref_mem[wa] = md_words[i];
    end

    for (int cyc = 0; cyc < 200 && post < 2; cyc++) begin
      @(negedge clk);
      ma_empty = popped;
      ma_addr  = addr;
      ma_dest  = dest;
      md_empty = (kind != 4) || (wr_idx >= LW) || (cyc >= stall_at && cyc < stall_at + stall_len);
      md_data  = (wr_idx < LW) ? md_words[wr_idx] : 32'h0;
      rs_ready = (rs_n >= ready_delay);
      #1;
      if (popped) post++;
      if (ma_rd) begin pops++; popped = 1; end
      if (mem_re) re_n++;
      if (mem_we) begin
        if (md_empty) wr_empty++;
        check({tag, ".wr_addr"}, 64'(mem_addr), 64'(line * LW + (wr_idx % LW)));
        check({tag, ".wr_data"}, 64'(mem_wdata), 64'(md_words[wr_idx % LW]));
        wr_idx++;
        wr_n++;
      end
      if (rd_dest != 4'd0) begin
        if (rd_first < 0) rd_first = cyc;
        check({tag, ".rd_dest"}, 64'(rd_dest), 64'(dest));
        check({tag, ".rd_data"}, 64'(rd_return), 64'(exp_words[rd_n % LW]));
        rd_n++;
      end
      if (rs_valid) begin
        check({tag, ".rs_data"}, 64'(rs_data), 64'(exp_rs));
        rs_n++;
      end
      if (err_oor) err_n++;
    end
    ma_empty = 1'b1;
    md_empty = 1'b1;
    rs_ready = 1'b0;

    check({tag, ".pops"}, 64'(pops), 64'd1);
    check({tag, ".strobes"}, 64'(re_n), (kind == 1) ? 64'(LW) : 64'd0);
    check({tag, ".rd_words"}, 64'(rd_n), (kind == 1) ? 64'(LW) : 64'd0);
    if (kind == 1) check({tag, ".rd_latency"}, 64'(rd_first), 64'd2);
    check({tag, ".writes"}, 64'(wr_n), (kind == 4) ? 64'(LW) : 64'd0);
    check({tag, ".write_while_empty"}, 64'(wr_empty), 64'd0);
    check({tag, ".rs_cycles"}, 64'(rs_n), (kind == 2 || kind == 3) ? 64'(ready_delay + 1) : 64'd0);
    check({tag, ".err_oor"}, 64'(err_n), oor ? 64'd1 : 64'd0);
    check({tag, ".nack_cnt"}, 64'(nack_cnt), 64'(ref_nack));
    if (!oor) check({tag, ".dir"}, 64'(dut.dir_q[line]), 64'(ref_dir[line]));
  endtask

  initial begin
    int lines [4] = '{32'h10, 32'h11, 32'h90, 32'h200};
    logic [31:0] a;

    rst_n    = 1'b0;
    ma_empty = 1'b0;
    ma_addr  = 32'h10000200;
    ma_dest  = 4'd3;
    md_empty = 1'b1;
    md_data  = '0;
    rs_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd1);
    check("reset.ma_rd", 64'(ma_rd), 64'd0);
    check("reset.mem_re", 64'(mem_re), 64'd0);
    check("reset.mem_we", 64'(mem_we), 64'd0);
    check("reset.rd_dest", 64'(rd_dest), 64'd0);
    check("reset.rs_valid", 64'(rs_valid), 64'd0);
    check("reset.rs_data", 64'(rs_data), 64'd0);
    check("reset.err_oor", 64'(err_oor), 64'd0);
    check("reset.nack_cnt", 64'(nack_cnt), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    rs_ready = 1'b0;
    wait_init("init");
    check("init.dir0", 64'(dut.dir_q[0]), 64'd2);
    check("init.dir127", 64'(dut.dir_q[127]), 64'd2);
    check("init.dir128", 64'(dut.dir_q[128]), 64'd0);
    check("init.dir_last", 64'(dut.dir_q[DIR_LINES-1]), 64'd0);

    run_req("read200", 32'h10000200, 4'd3, 0, 0, 0);
    run_req("excl300", 32'h30000300, 4'd5, 0, 0, 0);
    run_req("nack300", 32'h10000300, 4'd6, 2, 0, 0);
    run_req("retry300", 32'hB0000300, 4'd6, 0, 0, 0);
    run_req("write40", 32'h20000040, 4'd2, 0, 4, 5);
    run_req("retry40", 32'h90000040, 4'd2, 0, 0, 0);
    run_req("reread40", 32'h10000040, 4'd9, 0, 0, 0);
    run_req("ack500", 32'h50000500, 4'd7, 10, 0, 0);
    run_req("ack501", 32'h40000501, 4'd8, 0, 0, 0);
    run_req("oor", 32'h10FFFFFF, 4'd1, 0, 0, 0);
    check("oor.dir_last", 64'(dut.dir_q[DIR_LINES-1]), 64'(ref_dir[DIR_LINES-1]));

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      a[27:0] = 28'(lines[$urandom_range(0, 3)]);
      if ($urandom_range(0, 9) == 0) a[20] = 1'b1;
      run_req($sformatf("rand%0d", n), a, 4'($urandom_range(1, 15)),
              $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // Reset in the middle of a line read aborts it and restarts the directory sweep
    @(negedge clk);
    ma_empty = 1'b0;
    ma_addr  = 32'h10000200;
    ma_dest  = 4'd4;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.mem_re", 64'(mem_re), 64'd0);
    check("abort.ma_rd", 64'(ma_rd), 64'd0);
    check("abort.busy", 64'(busy), 64'd1);
    check("abort.rd_dest", 64'(rd_dest), 64'd0);
    ma_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    run_req("post_abort", 32'h10000200, 4'd4, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
